mul_sequencer: RTL and testbench
================================

// Module: mul_sequencer
// PURPOSE
//  Sequences the 64-bit Am2901/Am2904 datapath through an unsigned shift-add
//  multiply: clears the accumulator, then issues N multiply-step control words.
//  N is 32 or 64, chosen by mode32. Sits between the microprogram control
//  register and the datapath control inputs (Ialu, A, B, C0, Iss, nCEM, nCEN, mode32).
//  The microprogram preloads the multiplier into Q and the multiplicand into
//  RAM[ra]. Product high half ends in RAM[rb], low half in Q.
// PARAMETERS
//  STEP_ISS   10'h000  Am2904 Iss code for a step: carry into R63, R0 into Q63
//  IDLE_ISS   10'h000  Am2904 Iss code driven outside steps (no shift)
// PORTS
//  clk        in   1   clock
//  reset      in   1   asynchronous, active-high reset
//  start      in   1   request; sampled only in IDLE
//  abort      in   1   cancel the running sequence
//  mode32_in  in   1   1: 32-step multiply, 0: 64-step; latched at start
//  ra         in   4   multiplicand register address; latched at start
//  rb         in   4   accumulator register address; latched at start
//  q0         in   1   current Q[0] from the datapath (oQ0)
//  Ialu       out  9   Am2901 instruction {dest[8:6],func[5:3],src[2:0]}
//  A          out  4   A address to the datapath
//  B          out  4   B address to the datapath
//  C0         out  1   carry in (always 0)
//  Iss        out  10  Am2904 instruction
//  nCEM       out  1   machine status enable (active low)
//  nCEN       out  1   micro status enable (active low)
//  mode32     out  1   latched width flag to the datapath
//  busy       out  1   high in CLEAR and STEP
//  done       out  1   one-cycle pulse after the last step
// BEHAVIOUR
//  States: IDLE -> CLEAR -> STEP(xN) -> DONE -> IDLE. State is held in flops.
//  Ialu is decoded combinationally from state and q0. q0 is stable after each edge.
//  Reset:
//   - state=IDLE, counter=0, latched ra/rb=0, mode32=0
//   - Outputs: Ialu=9'b001_011_011 (NOP), A=B=0, C0=0, Iss=IDLE_ISS,
//     nCEM=nCEN=1, busy=0, done=0
//  IDLE:
//   - Drives the reset output values.
//   - start=1 latches mode32_in/ra/rb and goes to CLEAR.
//  CLEAR (1 cycle):
//   - Ialu=9'b011_100_011 (RAMF, AND, ZB), giving RAM[rb]<=0.
//   - Loads counter = mode32 ? 31 : 63.
//  STEP:
//   - q0=1: Ialu=9'b100_000_001 (RAMQD, ADD, AB); RAM[rb]<=(A+B)>>1, Q<=Q>>1.
//   - q0=0: Ialu=9'b100_000_011 (RAMQD, ADD, ZB); RAM[rb]<=B>>1, Q<=Q>>1.
//   - Iss=STEP_ISS, nCEN=0.
//   - Counter decrements each step. Counter==0 is the last step; next state is DONE.
//   - Counter is 6 bits, never wraps, and is loaded only in CLEAR.
//  DONE (1 cycle): done=1, busy=0, NOP word, then IDLE.
//  A=ra and B=rb in CLEAR and STEP; 0 otherwise. C0=0. nCEM=1 in every state.
//  Latency: start sampled at edge k. CLEAR is cycle k+1, STEP is k+2..k+N+1,
//   done=1 at k+N+2.
//  start while busy or in DONE: ignored, no queueing.
//  abort in CLEAR/STEP: next state IDLE, no done pulse; abort beats the last
//   step (no DONE). abort in IDLE/DONE: no effect.
//  abort and start in the same IDLE cycle: start wins.
//  reset mid-operation: immediate return to the reset values; register contents
//   are undefined for software.
// TESTING
//  1. mode32_in=1, Q=5, RAM[ra]=3, start -> 32 STEP cycles; done at start+34;
//     RAM[rb]=0, Q=15.
//  2. mode32_in=0, Q=64'hFFFF_FFFF_FFFF_FFFF, RAM[ra]=2 -> 64 steps;
//     RAM[rb]=1, Q=64'hFFFF_FFFF_FFFF_FFFE.
//  3. Drive q0 pattern 1,0,1 -> Ialu = 9'h101, 9'h103, 9'h101 with
//     A=ra and B=rb each cycle.
//  4. start pulsed at steps 3 and 10 of a run -> ignored; exactly one done per run.
//  5. abort at step 5 -> IDLE next cycle, no done, NOP word; new start runs a
//     full 32/64 steps.
//  6. reset asserted mid-STEP with no clock edge -> all outputs immediately at
//     reset values.

Source files
------------

// File: rtl/mul_sequencer.sv
// mul_sequencer
//   Drives the control inputs of the 64-bit Am2901/Am2904 datapath through an
//   unsigned shift-add multiply. It clears the accumulator register, then
//   issues N multiply-step control words, where N is 32 or 64 depending on
//   the width flag latched at start.
//
//   Before start, the microprogram loads the multiplier into Q and the
//   multiplicand into RAM[ra]. When the sequence ends, the high half of the
//   product is in RAM[rb] and the low half is in Q.
//
// Ports
//   clk        in   1   clock
//   reset      in   1   asynchronous, active-high reset
//   start      in   1   request; only looked at in IDLE
//   abort      in   1   cancel a running sequence (CLEAR/STEP)
//   mode32_in  in   1   1: 32-step multiply, 0: 64-step; latched at start
//   ra         in   4   multiplicand register address; latched at start
//   rb         in   4   accumulator register address; latched at start
//   q0         in   1   current Q[0] from the datapath
//   Ialu       out  9   Am2901 instruction {dest,func,src}
//   A, B       out  4   datapath register addresses
//   C0         out  1   carry in (always 0)
//   Iss        out  10  Am2904 shift/status instruction
//   nCEM       out  1   machine status enable, active low (never enabled)
//   nCEN       out  1   micro status enable, active low (enabled in STEP)
//   mode32     out  1   latched width flag to the datapath
//   busy       out  1   high in CLEAR and STEP
//   done       out  1   one-cycle pulse after the last step
module mul_sequencer #(
  parameter logic [9:0] STEP_ISS = 10'h000,
  parameter logic [9:0] IDLE_ISS = 10'h000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       mode32_in,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  input  logic       q0,
  output logic [8:0] Ialu,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       C0,
  output logic [9:0] Iss,
  output logic       nCEM,
  output logic       nCEN,
  output logic       mode32,
  output logic       busy,
  output logic       done
);

  // Am2901 control words used by the sequence.
  localparam logic [8:0] I_NOP     = 9'b001_011_011;  // NOP, no register write
  localparam logic [8:0] I_CLEAR   = 9'b011_100_011;  // RAMF, AND, ZB -> RAM[B] = 0
  localparam logic [8:0] I_STEP_AB = 9'b100_000_001;  // RAMQD, ADD, AB
  localparam logic [8:0] I_STEP_ZB = 9'b100_000_011;  // RAMQD, ADD, ZB

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_STEP  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q;
  logic [5:0] cnt_q;     // steps remaining after the current one
  logic [3:0] ra_q;
  logic [3:0] rb_q;
  logic       mode32_q;

  // Sequencing state. The counter is loaded only in CLEAR. It stops at zero,
  // and that zero marks the final step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      ra_q     <= 4'd0;
      rb_q     <= 4'd0;
      mode32_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // If start and abort arrive together, start wins: abort is not looked at here.
          if (start) begin
            mode32_q <= mode32_in;
            ra_q     <= ra;
            rb_q     <= rb;
            state_q  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= mode32_q ? 6'd31 : 6'd63;
            state_q <= S_STEP;
          end
        end
        S_STEP: begin
          // Abort has priority over the final step, so no done pulse follows.
          if (abort) begin
            state_q <= S_IDLE;
          end else if (cnt_q == 6'd0) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        default: begin  // S_DONE
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // The outputs are decoded only from the flops above and q0, with no edge in
  // between. An asynchronous reset therefore shows on the pins immediately.
  always_comb begin
    Ialu   = I_NOP;
    A      = 4'd0;
    B      = 4'd0;
    C0     = 1'b0;
    Iss    = IDLE_ISS;
    nCEM   = 1'b1;
    nCEN   = 1'b1;
    busy   = 1'b0;
    done   = 1'b0;
    mode32 = mode32_q;
    case (state_q)
      S_CLEAR: begin
        Ialu = I_CLEAR;
        A    = ra_q;
        B    = rb_q;
        busy = 1'b1;
      end
      S_STEP: begin
        // Add the multiplicand only when the multiplier bit shifting out is set.
        Ialu = q0 ? I_STEP_AB : I_STEP_ZB;
        A    = ra_q;
        B    = rb_q;
        Iss  = STEP_ISS;
        nCEN = 1'b0;
        busy = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

  localparam logic [9:0] P_STEP_ISS = 10'h155;
  localparam logic [9:0] P_IDLE_ISS = 10'h00A;
  localparam logic [8:0] NOP_W      = 9'h05B;
  localparam logic [8:0] CLEAR_W    = 9'h0E3;

  logic       clk = 1'b0;
  logic       reset, start, abort, mode32_in, q0;
  logic [3:0] ra, rb;
  logic [8:0] Ialu;
  logic [3:0] A, B;
  logic       C0, nCEM, nCEN, mode32, busy, done;
  logic [9:0] Iss;

  // A small behavioural datapath model. It supplies q0 and accumulates the product.
  logic [63:0] dp_ram [16];
  logic [63:0] dp_q;
  logic        q0_force_en, q0_force;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign q0 = q0_force_en ? q0_force : dp_q[0];

  mul_sequencer #(.STEP_ISS(P_STEP_ISS), .IDLE_ISS(P_IDLE_ISS)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .mode32_in(mode32_in), .ra(ra), .rb(rb), .q0(q0),
    .Ialu(Ialu), .A(A), .B(B), .C0(C0), .Iss(Iss),
    .nCEM(nCEM), .nCEN(nCEN), .mode32(mode32), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock. The datapath acts on the control word that was present
  // before the edge. Outputs are sampled 1 time unit after the edge.
  task automatic tick();
    logic [64:0] sum;
    logic [63:0] addend, nram, nq;
    logic        wr_ram, wr_q;
    logic [3:0]  b_addr;
    wr_ram = 1'b0; wr_q = 1'b0; nram = '0; nq = '0; sum = '0; addend = '0;
    b_addr = B;
    if (Ialu == CLEAR_W) begin
      wr_ram = 1'b1; nram = 64'd0;
    end else if (Ialu[8:6] == 3'b100) begin
      addend = (Ialu[2:0] == 3'b001) ? dp_ram[A] : 64'd0;
      wr_ram = 1'b1; wr_q = 1'b1;
      if (mode32) begin
        sum  = {33'd0, addend[31:0]} + {33'd0, dp_ram[b_addr][31:0]};
        nram = {32'd0, sum[32:1]};
        nq   = {32'd0, sum[0], dp_q[31:1]};
      end else begin
        sum  = {1'b0, addend} + {1'b0, dp_ram[b_addr]};
        nram = sum[64:1];
        nq   = {sum[0], dp_q[63:1]};
      end
    end
    @(posedge clk);
    if (wr_ram) dp_ram[b_addr] = nram;
    if (wr_q) dp_q = nq;
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ialu"}, 64'(Ialu), 64'(NOP_W));
    check({tag, "_ab"},   64'({A, B}), 64'd0);
    check({tag, "_iss"},  64'(Iss), 64'(P_IDLE_ISS));
    check({tag, "_ctl"},  64'({C0, nCEM, nCEN, busy, done}), 64'b01100);
  endtask

  // Runs one multiply. pa/pb are step numbers at which a stray start is
  // pulsed; ab is the step at which abort is asserted (0 = none).
  task automatic run_mul(input string name, input logic m, input logic [3:0] rav,
                         input logic [3:0] rbv, input logic [63:0] mcand,
                         input logic [63:0] mplier, input int pa, input int pb,
                         input int ab, output int done_cyc, output int done_cnt);
    int  cyc;
    int  n;
    logic did_abort;
    n = m ? 32 : 64;
    dp_ram[rav] = mcand;
    dp_ram[rbv] = 64'hA5A5_0000_1234_5678;
    dp_q = mplier;
    done_cyc = -1; done_cnt = 0;
    mode32_in = m; ra = rav; rb = rbv; start = 1'b1;
    tick();
    start = 1'b0; mode32_in = ~m; ra = 4'd0; rb = 4'd0;
    cyc = 1;
    check({name, "_clear_ialu"}, 64'(Ialu), 64'(CLEAR_W));
    check({name, "_clear_busy_mode"}, 64'({busy, mode32}), 64'({1'b1, m}));
    for (int i = 0; i < n + 12; i++) begin
      did_abort = (ab > 0) && (cyc - 1 == ab);
      abort = did_abort;
      start = (cyc - 1 == pa) || (cyc - 1 == pb);
      tick();
      cyc++;
      abort = 1'b0; start = 1'b0;
      if (did_abort) check_idle_outputs({name, "_abort"});
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
    $display("[TB] run %s mode32=%0b done_cycle=%0d dones=%0d hi=%0h lo=%0h",
             name, m, done_cyc, done_cnt, dp_ram[rbv], dp_q);
  endtask

  int dc, dn;

  initial begin
    for (int i = 0; i < 16; i++) dp_ram[i] = 64'd0;
    dp_q = 64'd0;
    q0_force_en = 1'b0; q0_force = 1'b0;
    start = 1'b0; abort = 1'b0; mode32_in = 1'b0; ra = 4'd0; rb = 4'd0;
    reset = 1'b1;
    #1;
    check_idle_outputs("reset");
    check("reset_mode32", 64'(mode32), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Test 1: 32-step multiply, 5 * 3 = 15.
    run_mul("t1", 1'b1, 4'd2, 4'd5, 64'd3, 64'd5, 0, 0, 0, dc, dn);
    check("t1_done_cycle", 64'(dc), 64'd34);
    check("t1_done_count", 64'(dn), 64'd1);
    check("t1_hi", dp_ram[5], 64'd0);
    check("t1_lo", dp_q, 64'd15);

    // Test 2: 64-step multiply, (2^64-1) * 2.
    run_mul("t2", 1'b0, 4'd7, 4'd9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, dc, dn);
    check("t2_done_cycle", 64'(dc), 64'd66);
    check("t2_hi", dp_ram[9], 64'd1);
    check("t2_lo", dp_q, 64'hFFFF_FFFF_FFFF_FFFE);

    // Test 3: q0 pattern 1,0,1 selects AB / ZB step words.
    dp_q = 64'd0;
    mode32_in = 1'b1; ra = 4'd3; rb = 4'd12; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    q0_force_en = 1'b1;
    q0_force = 1'b1; #1;
    check("t3_s1_ialu", 64'(Ialu), 64'h101);
    check("t3_s1_ab", 64'({A, B}), 64'({4'd3, 4'd12}));
    check("t3_s1_iss", 64'(Iss), 64'(P_STEP_ISS));
    check("t3_s1_ctl", 64'({C0, nCEM, nCEN, busy, done}), 64'b01010);
    tick();
    q0_force = 1'b0; #1;
    check("t3_s2_ialu", 64'(Ialu), 64'h103);
    check("t3_s2_ab", 64'({A, B}), 64'({4'd3, 4'd12}));
    tick();
    q0_force = 1'b1; #1;
    check("t3_s3_ialu", 64'(Ialu), 64'h101);
    check("t3_s3_ab", 64'({A, B}), 64'({4'd3, 4'd12}));
    abort = 1'b1;
    tick();
    abort = 1'b0; q0_force_en = 1'b0;
    check_idle_outputs("t3_abort");

    // Test 4: stray starts at steps 3 and 10 are ignored.
    run_mul("t4", 1'b1, 4'd1, 4'd4, 64'd7, 64'd9, 3, 10, 0, dc, dn);
    check("t4_done_cycle", 64'(dc), 64'd34);
    check("t4_done_count", 64'(dn), 64'd1);
    check("t4_lo", dp_q, 64'd63);

    // Test 5: abort at step 5, then a fresh full run.
    run_mul("t5a", 1'b1, 4'd1, 4'd4, 64'd7, 64'd9, 0, 0, 5, dc, dn);
    check("t5a_done_count", 64'(dn), 64'd0);
    run_mul("t5b", 1'b0, 4'd6, 4'd8, 64'd7, 64'd3, 0, 0, 0, dc, dn);
    check("t5b_done_cycle", 64'(dc), 64'd66);
    check("t5b_hi", dp_ram[8], 64'd0);
    check("t5b_lo", dp_q, 64'd21);

    // If start and abort arrive together in IDLE, start wins.
    mode32_in = 1'b1; ra = 4'd2; rb = 4'd3; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_beats_abort", 64'({busy, Ialu}), 64'({1'b1, CLEAR_W}));

    // Test 6: asynchronous reset mid-STEP, away from any clock edge.
    tick(); tick(); tick();
    check("t6_pre_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("t6_async");
    check("t6_mode32", 64'(mode32), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_idle_outputs("t6_after");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
